// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph table and nibble-to-segment helper for the
//               multiplexed seven-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] c_glyph_table [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] glyph_segments(input logic [3:0] nibble);
        return c_glyph_table[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_decode
// Description : Combinational hex nibble to active-high segment lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);
    import seg7_pkg::*;

    assign o_segments = glyph_segments(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : N-digit multiplexed seven-segment driver with PWM dimming,
//               anode guard time, leading-zero blanking and frame-synchronous
//               image updates. All pin outputs are active-low and registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    valid_in,
    input  logic                    lz_suppress_in,
    input  logic [BRIGHT_W-1:0]     brightness_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done_out
);
    import seg7_pkg::*;

    localparam int SLOT_W = $clog2(COUNT_PERIOD);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     c_slot_last  = SLOT_W'(COUNT_PERIOD - 1);
    localparam logic [SLOT_W-1:0]     c_slot_guard = SLOT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      c_idx_last   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one     = NUM_DIGITS'(1);

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [BRIGHT_W-1:0]     r_pwm_cnt;

    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;

    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;

    logic [6:0]              r_cat;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_last;
    logic                    w_frame_end;
    logic                    w_pwm_on;
    logic                    w_lit;
    logic                    w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic                    w_supp_sel;
    logic [6:0]              w_segments;

    assign w_slot_last = (r_slot_cnt == c_slot_last);
    assign w_frame_end = w_slot_last && (r_digit_idx == c_idx_last);
    assign w_pwm_on    = (r_pwm_cnt <= brightness_in);

    // A digit is blanked when it and every digit to its left hold zero
    always_comb begin
        w_upper_zero = 1'b1;
        w_supp       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero && (r_act_val[4*i +: 4] == 4'h0);
            w_supp[i]    = lz_suppress_in && w_upper_zero;
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b1;
        w_supp_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble    = r_act_val[4*i +: 4];
                w_dp_sel    = r_act_dp[i];
                w_blank_sel = r_act_blank[i];
                w_supp_sel  = w_supp[i];
            end
        end
    end

    assign w_lit = !w_blank_sel && !w_supp_sel && w_pwm_on && (r_slot_cnt >= c_slot_guard);

    seg7_glyph_decode u_glyph (
        .i_nibble   (w_nibble),
        .o_segments (w_segments)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_slot_cnt   <= '0;
            r_digit_idx  <= '0;
            r_pwm_cnt    <= '0;
            r_pending    <= 1'b0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_cat        <= ~SEG_OFF;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_last) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == c_idx_last) ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
            end
            r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);

            if (valid_in) begin
                r_pend_val   <= val_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
            end

            // Live inputs on the boundary cycle take priority over the shadow copy
            if (w_frame_end) begin
                r_pending <= 1'b0;
                if (valid_in) begin
                    r_act_val   <= val_in;
                    r_act_dp    <= dp_in;
                    r_act_blank <= blank_in;
                end else if (r_pending) begin
                    r_act_val   <= r_pend_val;
                    r_act_dp    <= r_pend_dp;
                    r_act_blank <= r_pend_blank;
                end
            end else if (valid_in) begin
                r_pending <= 1'b1;
            end

            r_frame_done <= w_frame_end;

            if (w_lit) begin
                r_an  <= ~(c_an_one << r_digit_idx);
                r_cat <= ~w_segments;
                r_dp  <= ~w_dp_sel;
            end else begin
                r_an  <= '1;
                r_cat <= ~SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign cat_out        = r_cat;
    assign dp_out         = r_dp;
    assign an_out         = r_an;
    assign frame_done_out = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_display
// Description : Self-checking bench for seg7_scan_display (4 digits, 8-cycle
//               slots, 1 guard cycle, 2-bit brightness).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        valid = 1'b0;
    logic        lz = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done_out;

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state
    int          m_slot = 0, m_idx = 0, m_pwm = 0;
    bit          m_pend = 0;
    logic [15:0] m_pval = '0, m_aval = '0;
    logic [3:0]  m_pdp = '0, m_pblank = '1, m_adp = '0, m_ablank = '1;

    logic [12:0] sb [$];

    seg7_scan_display #(
        .NUM_DIGITS   (4),
        .COUNT_PERIOD (8),
        .GUARD_CYCLES (1),
        .BRIGHT_W     (2)
    ) u_dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .val_in         (val),
        .dp_in          (dp),
        .blank_in       (blank),
        .valid_in       (valid),
        .lz_suppress_in (lz),
        .brightness_in  (bright),
        .cat_out        (cat_out),
        .dp_out         (dp_out),
        .an_out         (an_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the next edge, advance the model, clock, compare.
    task automatic tick();
        logic [12:0] e, got;
        int          hi;
        bit          supp, lit, fd;
        logic [3:0]  nib;
        if (rst) begin
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            hi = -1;
            for (int k = 0; k < 4; k++) if (m_aval[4*k +: 4] != 4'h0) hi = k;
            nib  = m_aval[4*m_idx +: 4];
            supp = lz && (m_idx > 0) && (m_idx > hi);
            lit  = !m_ablank[m_idx] && !supp && (m_pwm <= int'(bright)) && (m_slot >= 1);
            fd   = (m_idx == 3) && (m_slot == 7);
            if (lit) e = {~(4'b0001 << m_idx), ~glyph[nib], ~m_adp[m_idx], fd};
            else     e = {4'hF, 7'h7F, 1'b1, fd};
        end
        sb.push_back(e);

        if (rst) begin
            m_slot = 0; m_idx = 0; m_pwm = 0; m_pend = 0;
            m_aval = '0; m_adp = '0; m_ablank = '1;
        end else begin
            if ((m_idx == 3) && (m_slot == 7)) begin
                if (valid) begin
                    m_aval = val; m_adp = dp; m_ablank = blank;
                end else if (m_pend) begin
                    m_aval = m_pval; m_adp = m_pdp; m_ablank = m_pblank;
                end
                m_pend = 0;
            end else if (valid) begin
                m_pend = 1;
            end
            if (valid) begin
                m_pval = val; m_pdp = dp; m_pblank = blank;
            end
            if (m_slot == 7) begin
                m_slot = 0;
                m_idx  = (m_idx + 1) % 4;
            end else begin
                m_slot++;
            end
            m_pwm = (m_pwm + 1) % 4;
        end

        @(posedge clk);
        #1;
        got = {an_out, cat_out, dp_out, frame_done_out};
        e   = sb.pop_front();
        n_total++;
        assert (got === e) else begin
            n_bad++;
            $error("FAIL scan t=%0t observed=%h expected=%h", $time, got, e);
        end
    endtask

    // Advance until the sampled outputs reflect scan state (idx, slot)
    task automatic show(input int idx, input int slot);
        int n = 0;
        while (!(m_idx == idx && m_slot == slot) && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) check("show_timeout", 16'(n), 16'd0);
        tick();
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_done_out !== 1'b1 && n < 80);
        check("fd_seen", {15'd0, frame_done_out}, 16'd1);
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        val = v; dp = d; blank = 4'h0; valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic count_lit4(output int c);
        int n = 0;
        c = 0;
        while (m_slot != 1 && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (an_out != 4'hF) c++;
        end
    endtask

    initial begin
        int fd_cnt, on_cnt, c;
        repeat (3) tick();
        check("reset_an", {12'd0, an_out}, 16'h000F);
        check("reset_cat", {9'd0, cat_out}, 16'h007F);
        check("reset_fd", {15'd0, frame_done_out}, 16'd0);
        rst = 1'b0;

        // Dark display, frame pulse every 32 cycles
        fd_cnt = 0; on_cnt = 0;
        for (int k = 0; k < 96; k++) begin
            tick();
            if (frame_done_out) fd_cnt++;
            if (an_out != 4'hF) on_cnt++;
        end
        check("idle_fd_count", 16'(fd_cnt), 16'd3);
        check("idle_dark", 16'(on_cnt), 16'd0);

        // Basic image
        send(16'h12AF, 4'b0010);
        wait_fd();
        show(0, 0);
        check("guard_an", {12'd0, an_out}, 16'h000F);
        show(0, 1);
        check("d0_an", {12'd0, an_out}, 16'h000E);
        check("d0_cat", {9'd0, cat_out}, 16'h000E);
        check("d0_dp", {15'd0, dp_out}, 16'd1);
        show(1, 1);
        check("d1_an", {12'd0, an_out}, 16'h000D);
        check("d1_cat", {9'd0, cat_out}, 16'h0008);
        check("d1_dp", {15'd0, dp_out}, 16'd0);
        show(2, 1);
        check("d2_cat", {9'd0, cat_out}, 16'h0024);
        show(3, 1);
        check("d3_cat", {9'd0, cat_out}, 16'h0079);

        // Leading-zero suppression
        lz = 1'b1;
        send(16'h0005, 4'b0000);
        wait_fd();
        show(0, 1);
        check("lz5_d0_cat", {9'd0, cat_out}, 16'h0012);
        show(1, 1);
        check("lz5_d1_dark", {12'd0, an_out}, 16'h000F);
        send(16'h0000, 4'b0000);
        wait_fd();
        show(0, 1);
        check("lz0_d0_cat", {9'd0, cat_out}, 16'h0040);
        show(2, 3);
        check("lz0_d2_dark", {12'd0, an_out}, 16'h000F);
        lz = 1'b0;

        // PWM duty
        send(16'h12AF, 4'b0000);
        wait_fd();
        bright = 2'd1;
        count_lit4(c);
        check("pwm_b1", 16'(c), 16'd2);
        bright = 2'd0;
        count_lit4(c);
        check("pwm_b0", 16'(c), 16'd1);
        bright = 2'd3;

        // Mid-frame update is deferred to the next frame
        show(2, 2);
        send(16'h1111, 4'b0000);
        show(2, 5);
        check("tear_old_d2", {9'd0, cat_out}, 16'h0024);
        wait_fd();
        show(0, 1);
        check("tear_new_d0", {9'd0, cat_out}, 16'h0079);
        show(2, 1);
        check("tear_new_d2", {9'd0, cat_out}, 16'h0079);

        // Update on the boundary cycle itself
        show(3, 6);
        send(16'h3456, 4'b0000);
        check("b_cycle_fd", {15'd0, frame_done_out}, 16'd1);
        show(0, 1);
        check("b_cycle_d0", {9'd0, cat_out}, 16'h0002);
        show(1, 1);
        check("b_cycle_d1", {9'd0, cat_out}, 16'h0012);

        // Reset drops a pending update
        show(1, 2);
        send(16'h8888, 4'b0000);
        show(2, 3);
        rst = 1'b1;
        tick();
        check("rst_mid_an", {12'd0, an_out}, 16'h000F);
        check("rst_mid_cat", {9'd0, cat_out}, 16'h007F);
        rst = 1'b0;
        on_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (an_out != 4'hF) on_cnt++;
        end
        check("rst_drop_pending", 16'(on_cnt), 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment driver for N digits. Adds per-digit decimal points, per-digit blanking, leading-zero suppression, PWM brightness, anode guard time against ghosting, and tear-free frame-synchronous updates.
- Sits between status/debug logic (pitch, frequency readouts) and board cathode/anode pins.
- All outputs are active-low.

Parameters:
- NUM_DIGITS, 8, digits scanned; legal 1..16.
- COUNT_PERIOD, 100000, clk_in cycles per digit slot; must be >= 2.
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < COUNT_PERIOD.
- BRIGHT_W, 4, width of the brightness control.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- val_in  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  input  NUM_DIGITS  1 = force digit dark
- valid_in  input  1  capture val_in/dp_in/blank_in as pending update
- lz_suppress_in  input  1  1 = blank leading zero digits
- brightness_in  input  BRIGHT_W  PWM duty control
- cat_out  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_out  output  1  decimal point cathode, active-low
- an_out  output  NUM_DIGITS  digit anodes, active-low, at most one low
- frame_done_out  output  1  one-cycle pulse when a scan frame completes and the active image updates

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values:
  - Outputs: an_out all 1, cat_out 7'h7F, dp_out 1, frame_done_out 0.
  - State: slot_cnt 0, digit_idx 0, pwm_cnt 0, pending flag 0.
  - Active image: val 0, dp 0, blank all ones, so the display stays dark until the first update.
  - Reset mid-frame aborts the scan immediately. Any pending update is discarded.
- Scan:
  - slot_cnt counts 0..COUNT_PERIOD-1.
  - At COUNT_PERIOD-1, slot_cnt wraps to 0 and digit_idx advances. digit_idx wraps from NUM_DIGITS-1 to 0.
  - Frame boundary B = (digit_idx==NUM_DIGITS-1) and (slot_cnt==COUNT_PERIOD-1).
- Update handshake:
  - When valid_in is high, the inputs are captured into the pending registers and pending is set. A later valid_in overwrites pending (last writer wins).
  - On the edge where B is true:
    - If valid_in is high, the active image loads the live inputs.
    - Else, if pending is set, the active image loads the pending registers.
    - pending clears.
    - frame_done_out is 1 for exactly the next cycle. It pulses every frame, whether or not an update occurred.
  - The active image never changes mid-frame.
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter that wraps.
  - pwm_on = (pwm_cnt <= brightness_in).
  - Duty is (brightness_in+1)/2^BRIGHT_W, so an all-ones setting gives full on.
- Leading-zero suppression:
  - Digit i (i >= 1) is suppressed when lz_suppress_in=1 and active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - dp is ignored for suppression; a suppressed digit shows no dp.
- Digit lit condition: lit = !blank[d] && !suppressed[d] && pwm_on && (slot_cnt >= GUARD_CYCLES), where d = digit_idx.
- Registered outputs (one-cycle latency from the state above):
  - If lit: an_out has bit d low; cat_out = ~glyph(nibble d); dp_out = ~dp[d].
  - If not lit: an_out all 1, cat_out 7'h7F, dp_out 1.
- Glyphs (active-high {g,f,e,d,c,b,a}):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Widths:
  - slot_cnt is sized $clog2(COUNT_PERIOD).
  - digit_idx is sized max(1, $clog2(NUM_DIGITS)).
  - No arithmetic overflow is permitted.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry glyph constant array;
  - SEG_OFF = 7'h00;
  - a function returning active-high segments for a nibble.
- Sub-module seg7_glyph_decode: combinational nibble-to-segment lookup using the package. The top holds all counters, the shadow/active registers, the suppression logic and the output registers.

Test Plan (NUM_DIGITS=4, COUNT_PERIOD=8, GUARD_CYCLES=1, BRIGHT_W=2, brightness 3 unless stated):
- Reset, no valid_in for 3 frames -> an_out stays 4'hF, cat_out 7'h7F; frame_done_out pulses every 32 cycles.
- valid_in=1 for one cycle with val_in=16'h12AF, dp_in=4'b0010, blank_in=0; wait for frame_done_out -> next frame:
  - digit0: an 4'b1110, cat 7'h0E, dp 1;
  - digit1: an 4'b1101, cat 7'h08, dp 0;
  - digit2 cat 7'h24; digit3 cat 7'h79;
  - each digit is dark for the first slot cycle, then lit for 7.
- lz_suppress_in=1 with val 16'h0005 -> only digit 0 lit (cat 7'h12). With val 16'h0000 -> digit 0 shows cat 7'h40, digits 1-3 dark.
- brightness_in=1 -> inside each slot after the guard cycle, the anode is low on exactly 2 of every 4 cycles. brightness_in=0 -> 1 of 4.
- Tear-free update:
  - valid_in with 16'h1111 at digit 2 mid-frame -> the remaining digits still show the old image; the new image appears from the frame after frame_done_out.
  - valid_in asserted exactly on the B cycle -> applied in the very next frame.
- Reset asserted mid-frame with an update pending -> outputs go dark the next cycle; after release the display stays blank, proving the pending update was dropped.
